date_cal: RTL and testbench

//  Calendar stage directly downstream of the 24-hour counter. Advances a BCD day/month/year

---
 rtl/date_pkg.sv | 49 ++++
 rtl/date_cal_if.sv | 29 ++
 rtl/month_len.sv | 22 ++
 rtl/date_cal.sv | 102 ++++++++++
 tb/tb_date_cal.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/date_pkg.sv
// BCD calendar constants and helpers shared by the date stage.
// Purely combinational definitions: no latency, no flow control.
package date_pkg;

    localparam logic [7:0] JAN = 8'h01;
    localparam logic [7:0] FEB = 8'h02;
    localparam logic [7:0] MAR = 8'h03;
    localparam logic [7:0] APR = 8'h04;
    localparam logic [7:0] MAY = 8'h05;
    localparam logic [7:0] JUN = 8'h06;
    localparam logic [7:0] JUL = 8'h07;
    localparam logic [7:0] AUG = 8'h08;
    localparam logic [7:0] SEP = 8'h09;
    localparam logic [7:0] OCT = 8'h10;
    localparam logic [7:0] NOV = 8'h11;
    localparam logic [7:0] DEC = 8'h12;

    localparam logic [7:0] DAYS_28 = 8'h28;
    localparam logic [7:0] DAYS_29 = 8'h29;
    localparam logic [7:0] DAYS_30 = 8'h30;
    localparam logic [7:0] DAYS_31 = 8'h31;

    // Year mod 4 == 0 without a divider: tens parity selects which ones digits qualify.
    function automatic logic is_leap_bcd(input logic [3:0] year1, input logic [3:0] year0);
        if (!year1[0])
            return (year0 == 4'd0) || (year0 == 4'd4) || (year0 == 4'd8);
        else
            return (year0 == 4'd2) || (year0 == 4'd6);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones >= 4'd9) begin
            ones = 4'd0;
            tens = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/date_cal_if.sv
// Date-stage bus: advance/set requests in, BCD digit pairs and status pulses out.
// Signals only; no latency or handshake of its own.
interface date_cal_if;

    logic       day_en;
    logic       set_en;
    logic [7:0] set_day;
    logic [7:0] set_month;
    logic [7:0] set_year;
    logic [3:0] day1;
    logic [3:0] day0;
    logic [3:0] month1;
    logic [3:0] month0;
    logic [3:0] year1;
    logic [3:0] year0;
    logic       century_en;
    logic       set_err;

    modport master (
        output day_en, set_en, set_day, set_month, set_year,
        input  day1, day0, month1, month0, year1, year0, century_en, set_err
    );

    modport slave (
        input  day_en, set_en, set_day, set_month, set_year,
        output day1, day0, month1, month0, year1, year0, century_en, set_err
    );

endinterface

// File: rtl/month_len.sv
// Last day of a BCD month, given whether the year is leap.
// Combinational, zero latency, no backpressure; unknown months report 31.
module month_len
    import date_pkg::*;
#(
    parameter int LEAP_EN = 1
) (
    input  logic [7:0] month,
    input  logic       leap,
    output logic [7:0] last_day
);

    always_comb begin
        last_day = DAYS_31;
        case (month)
            APR, JUN, SEP, NOV: last_day = DAYS_30;
            FEB:                last_day = ((LEAP_EN != 0) && leap) ? DAYS_29 : DAYS_28;
            default:            last_day = DAYS_31;
        endcase
    end

endmodule

// File: rtl/date_cal.sv
// BCD day/month/year calendar advanced by day_en, with a validated set port.
// 1-cycle latency, registered outputs; set_en wins over day_en, no backpressure.
module date_cal
    import date_pkg::*;
#(
    parameter logic [7:0] RST_YEAR = 8'h00,
    parameter int         LEAP_EN  = 1
) (
    input  logic         clk_i,
    input  logic         rst,
    date_cal_if.slave    bus
);

    logic [7:0] day_q, month_q, year_q;
    logic       century_q, set_err_q;

    logic [7:0] cur_last, set_last;
    logic       cur_leap, set_leap;

    logic       month_ok, day_wrap, year_wrap;
    logic [7:0] nxt_day, nxt_month, nxt_year;
    logic       set_ok;

    assign cur_leap = is_leap_bcd(year_q[7:4], year_q[3:0]);
    assign set_leap = is_leap_bcd(bus.set_year[7:4], bus.set_year[3:0]);

    month_len #(.LEAP_EN(LEAP_EN)) u_cur_len (
        .month    (month_q),
        .leap     (cur_leap),
        .last_day (cur_last)
    );

    month_len #(.LEAP_EN(LEAP_EN)) u_set_len (
        .month    (bus.set_month),
        .leap     (set_leap),
        .last_day (set_last)
    );

    // Illegal register contents fall through to the wrap path so one day_en recovers.
    always_comb begin
        month_ok  = bcd_ok(month_q) && (month_q >= JAN) && (month_q <= DEC);
        day_wrap  = !month_ok || !bcd_ok(day_q) || (day_q >= cur_last);
        year_wrap = 1'b0;
        nxt_day   = day_wrap ? 8'h01 : bcd_inc(day_q);
        nxt_month = month_q;
        nxt_year  = year_q;
        if (!month_ok) begin
            nxt_month = JAN;
        end else if (day_wrap) begin
            if (month_q == DEC) begin
                nxt_month = JAN;
                nxt_year  = bcd_inc(year_q);
                year_wrap = (year_q == 8'h99);
            end else begin
                nxt_month = bcd_inc(month_q);
            end
        end
    end

    always_comb begin
        set_ok = bcd_ok(bus.set_day) && bcd_ok(bus.set_month) && bcd_ok(bus.set_year)
              && (bus.set_month >= JAN) && (bus.set_month <= DEC)
              && (bus.set_day >= 8'h01) && (bus.set_day <= set_last);
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            day_q     <= 8'h01;
            month_q   <= JAN;
            year_q    <= RST_YEAR;
            century_q <= 1'b0;
            set_err_q <= 1'b0;
        end else begin
            century_q <= 1'b0;
            set_err_q <= 1'b0;
            if (bus.set_en) begin
                if (set_ok) begin
                    day_q   <= bus.set_day;
                    month_q <= bus.set_month;
                    year_q  <= bus.set_year;
                end else begin
                    set_err_q <= 1'b1;
                end
            end else if (bus.day_en) begin
                day_q     <= nxt_day;
                month_q   <= nxt_month;
                year_q    <= nxt_year;
                century_q <= year_wrap;
            end
        end
    end

    assign bus.day1       = day_q[7:4];
    assign bus.day0       = day_q[3:0];
    assign bus.month1     = month_q[7:4];
    assign bus.month0     = month_q[3:0];
    assign bus.year1      = year_q[7:4];
    assign bus.year0      = year_q[3:0];
    assign bus.century_en = century_q;
    assign bus.set_err    = set_err_q;

endmodule

// File: tb/tb_date_cal.sv
// Scoreboarded directed test of date_cal: one leap-enabled instance, one with LEAP_EN=0.
module tb_date_cal;

    logic clk_i = 1'b0;
    logic rst   = 1'b1;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    date_cal_if b0 ();
    date_cal_if b1 ();

    date_cal #(.RST_YEAR(8'h00), .LEAP_EN(1)) u_dut0 (.clk_i(clk_i), .rst(rst), .bus(b0));
    date_cal #(.RST_YEAR(8'h24), .LEAP_EN(0)) u_dut1 (.clk_i(clk_i), .rst(rst), .bus(b1));

    typedef struct {
        int          due;
        int          id;
        logic [25:0] v;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   id_ctr = 0;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [25:0] obs0();
        return {b0.day1, b0.day0, b0.month1, b0.month0, b0.year1, b0.year0, b0.century_en, b0.set_err};
    endfunction

    function automatic logic [25:0] obs1();
        return {b1.day1, b1.day0, b1.month1, b1.month0, b1.year1, b1.year0, b1.century_en, b1.set_err};
    endfunction

    task automatic check(input string name, input int id, input logic [25:0] act, input logic [25:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s #%0d: got d/m/y %h/%h/%h cen=%b err=%b, want %h/%h/%h cen=%b err=%b",
                     name, id, act[25:18], act[17:10], act[9:2], act[1], act[0],
                     req[25:18], req[17:10], req[9:2], req[1], req[0]);
        end
    endtask

    // Monitor: compares every expectation whose sampling edge has passed.
    always @(negedge clk_i) begin
        while (q0.size() > 0 && q0[0].due <= cyc) begin
            exp_t e;
            e = q0.pop_front();
            check("dut0", e.id, obs0(), e.v);
        end
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            exp_t e;
            e = q1.pop_front();
            check("dut1", e.id, obs1(), e.v);
        end
    end

    task automatic idle_bus();
        b0.day_en = 0; b0.set_en = 0; b0.set_day = 0; b0.set_month = 0; b0.set_year = 0;
        b1.day_en = 0; b1.set_en = 0; b1.set_day = 0; b1.set_month = 0; b1.set_year = 0;
    endtask

    // Drives one cycle of stimulus on instance u and queues the state expected after the edge.
    task automatic drive(input int u, input bit de, input bit se,
                         input logic [7:0] sd, input logic [7:0] sm, input logic [7:0] sy,
                         input logic [7:0] ed, input logic [7:0] em, input logic [7:0] ey,
                         input bit ec, input bit es);
        exp_t e;
        @(posedge clk_i);
        #1;
        idle_bus();
        if (u == 0) begin
            b0.day_en = de; b0.set_en = se; b0.set_day = sd; b0.set_month = sm; b0.set_year = sy;
        end else begin
            b1.day_en = de; b1.set_en = se; b1.set_day = sd; b1.set_month = sm; b1.set_year = sy;
        end
        e.due = cyc + 1;
        e.id  = id_ctr++;
        e.v   = {ed, em, ey, ec, es};
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic day_step(input int u, input logic [7:0] ed, input logic [7:0] em,
                            input logic [7:0] ey, input bit ec);
        drive(u, 1, 0, 8'h00, 8'h00, 8'h00, ed, em, ey, ec, 0);
    endtask

    task automatic set_req(input int u, input logic [7:0] sd, input logic [7:0] sm,
                           input logic [7:0] sy, input logic [7:0] ed, input logic [7:0] em,
                           input logic [7:0] ey, input bit es);
        drive(u, 0, 1, sd, sm, sy, ed, em, ey, 0, es);
    endtask

    task automatic hold(input int u, input logic [7:0] ed, input logic [7:0] em, input logic [7:0] ey);
        drive(u, 0, 0, 8'h00, 8'h00, 8'h00, ed, em, ey, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        rst = 1'b1;
        #12;
        check("rst_state0", 0, obs0(), {8'h01, 8'h01, 8'h00, 1'b0, 1'b0});
        check("rst_state1", 0, obs1(), {8'h01, 8'h01, 8'h24, 1'b0, 1'b0});
        @(negedge clk_i);
        rst = 1'b0;

        hold(0, 8'h01, 8'h01, 8'h00);
        hold(1, 8'h01, 8'h01, 8'h24);

        // January walk: 01/01/00 advances to 01/02/00 after 31 days.
        for (int i = 1; i <= 31; i++) begin
            if (i < 31) day_step(0, bcd(i + 1), 8'h01, 8'h00, 0);
            else        day_step(0, 8'h01, 8'h02, 8'h00, 0);
        end

        set_req(0, 8'h28, 8'h02, 8'h23, 8'h28, 8'h02, 8'h23, 0);
        day_step(0, 8'h01, 8'h03, 8'h23, 0);
        set_req(0, 8'h28, 8'h02, 8'h24, 8'h28, 8'h02, 8'h24, 0);
        day_step(0, 8'h29, 8'h02, 8'h24, 0);
        day_step(0, 8'h01, 8'h03, 8'h24, 0);
        set_req(0, 8'h30, 8'h04, 8'h24, 8'h30, 8'h04, 8'h24, 0);
        day_step(0, 8'h01, 8'h05, 8'h24, 0);
        set_req(0, 8'h19, 8'h09, 8'h24, 8'h19, 8'h09, 8'h24, 0);
        day_step(0, 8'h20, 8'h09, 8'h24, 0);

        set_req(0, 8'h31, 8'h12, 8'h99, 8'h31, 8'h12, 8'h99, 0);
        day_step(0, 8'h01, 8'h01, 8'h00, 1);
        hold(0, 8'h01, 8'h01, 8'h00);

        set_req(0, 8'h31, 8'h04, 8'h10, 8'h01, 8'h01, 8'h00, 1);
        hold(0, 8'h01, 8'h01, 8'h00);
        set_req(0, 8'h29, 8'h02, 8'h23, 8'h01, 8'h01, 8'h00, 1);
        set_req(0, 8'h10, 8'h13, 8'h10, 8'h01, 8'h01, 8'h00, 1);
        set_req(0, 8'h0A, 8'h01, 8'h10, 8'h01, 8'h01, 8'h00, 1);
        set_req(0, 8'h00, 8'h05, 8'h10, 8'h01, 8'h01, 8'h00, 1);
        hold(0, 8'h01, 8'h01, 8'h00);
        set_req(0, 8'h29, 8'h02, 8'h00, 8'h29, 8'h02, 8'h00, 0);

        drive(0, 1, 1, 8'h15, 8'h06, 8'h50, 8'h15, 8'h06, 8'h50, 0, 0);
        day_step(0, 8'h16, 8'h06, 8'h50, 0);
        day_step(0, 8'h17, 8'h06, 8'h50, 0);

        // Async reset between edges while day_en is still asserted.
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst0", 1, obs0(), {8'h01, 8'h01, 8'h00, 1'b0, 1'b0});
        check("async_rst1", 1, obs1(), {8'h01, 8'h01, 8'h24, 1'b0, 1'b0});
        idle_bus();
        @(negedge clk_i);
        rst = 1'b0;
        hold(0, 8'h01, 8'h01, 8'h00);

        set_req(1, 8'h29, 8'h02, 8'h24, 8'h01, 8'h01, 8'h24, 1);
        set_req(1, 8'h28, 8'h02, 8'h24, 8'h28, 8'h02, 8'h24, 0);
        day_step(1, 8'h01, 8'h03, 8'h24, 0);

        hold(0, 8'h01, 8'h01, 8'h00);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d/%0d entries left, want 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
